// File: rtl/div_arb.sv
// Two-requester round-robin front end for a shared iterative divider.
// Serialises one operation at a time and aborts a stalled divider after TIMEOUT cycles.
module div_arb #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_dividend_i,
    input  logic [31:0] req0_divisor_i,
    input  logic [2:0]  req0_op_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_dividend_i,
    input  logic [31:0] req1_divisor_i,
    input  logic [2:0]  req1_op_i,
    output logic        rsp0_valid_o,
    input  logic        rsp0_ready_i,
    output logic [31:0] rsp0_data_o,
    output logic        rsp0_err_o,
    output logic        rsp1_valid_o,
    input  logic        rsp1_ready_i,
    output logic [31:0] rsp1_data_o,
    output logic        rsp1_err_o,
    output logic        div_start_o,
    output logic [31:0] div_dividend_o,
    output logic [31:0] div_divisor_o,
    output logic [2:0]  div_op_o,
    input  logic [31:0] div_result_i,
    input  logic        div_res_valid_i,
    output logic        div_res_ready_o
);

    localparam int unsigned DW  = 32;
    localparam int unsigned OPW = 3;
    localparam int unsigned CW  = 8;

    typedef enum logic [1:0] {IDLE, BUSY, ABORT, RESP} state_t;

    state_t          state, state_d;
    logic            last_grant;
    logic            owner;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   dividend_q, divisor_q, result_q;
    logic [OPW-1:0]  op_q;
    logic            err_q;

    logic            grant_c;
    logic            accept_c;
    logic            owner_ready_c;
    logic            timeout_c;

    // Next-state and output decode
    always_comb begin
        state_d         = state;
        accept_c        = 1'b0;
        req0_ready_o    = 1'b0;
        req1_ready_o    = 1'b0;
        rsp0_valid_o    = 1'b0;
        rsp0_data_o     = '0;
        rsp0_err_o      = 1'b0;
        rsp1_valid_o    = 1'b0;
        rsp1_data_o     = '0;
        rsp1_err_o      = 1'b0;
        div_start_o     = 1'b0;
        div_dividend_o  = '0;
        div_divisor_o   = '0;
        div_op_o        = '0;
        div_res_ready_o = 1'b0;

        // Contention goes to whoever was not granted last; otherwise to the lone requester
        if (req0_valid_i && req1_valid_i) grant_c = ~last_grant;
        else                              grant_c = req1_valid_i;

        owner_ready_c = owner ? rsp1_ready_i : rsp0_ready_i;
        timeout_c     = (cnt + CW'(1)) == CW'(TIMEOUT);

        case (state)
            IDLE: begin
                req0_ready_o = req0_valid_i && !grant_c;
                req1_ready_o = req1_valid_i && grant_c;
                accept_c     = req0_valid_i || req1_valid_i;
                if (accept_c) state_d = BUSY;
            end
            BUSY: begin
                div_start_o     = 1'b1;
                div_res_ready_o = 1'b1;
                div_dividend_o  = dividend_q;
                div_divisor_o   = divisor_q;
                div_op_o        = op_q;
                if (div_res_valid_i) state_d = RESP;
                else if (timeout_c)  state_d = ABORT;
            end
            ABORT: state_d = RESP;
            RESP: begin
                rsp0_valid_o = !owner;
                rsp1_valid_o = owner;
                rsp0_data_o  = owner ? '0 : result_q;
                rsp1_data_o  = owner ? result_q : '0;
                rsp0_err_o   = !owner && err_q;
                rsp1_err_o   = owner && err_q;
                if (owner_ready_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and operation datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            op_q       <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        dividend_q <= grant_c ? req1_dividend_i : req0_dividend_i;
                        divisor_q  <= grant_c ? req1_divisor_i  : req0_divisor_i;
                        op_q       <= grant_c ? req1_op_i       : req0_op_i;
                        owner      <= grant_c;
                        last_grant <= grant_c;
                        cnt        <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (div_res_valid_i) begin
                        result_q <= div_result_i;
                        err_q    <= 1'b0;
                    end
                end
                ABORT: begin
                    result_q <= '0;
                    err_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arb.sv
// Directed bench for div_arb: the bench itself plays the divider and both requesters.
module tb_div_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [31:0] req0_dividend_i, req0_divisor_i, req1_dividend_i, req1_divisor_i;
    logic [2:0]  req0_op_i, req1_op_i;
    logic        rsp0_valid_o, rsp0_ready_i, rsp0_err_o;
    logic        rsp1_valid_o, rsp1_ready_i, rsp1_err_o;
    logic [31:0] rsp0_data_o, rsp1_data_o;
    logic        div_start_o, div_res_valid_i, div_res_ready_o;
    logic [31:0] div_dividend_o, div_divisor_o, div_result_i;
    logic [2:0]  div_op_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_arb #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_dividend_i(req0_dividend_i), .req0_divisor_i(req0_divisor_i), .req0_op_i(req0_op_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_dividend_i(req1_dividend_i), .req1_divisor_i(req1_divisor_i), .req1_op_i(req1_op_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
        .rsp0_data_o(rsp0_data_o), .rsp0_err_o(rsp0_err_o),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
        .rsp1_data_o(rsp1_data_o), .rsp1_err_o(rsp1_err_o),
        .div_start_o(div_start_o), .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
        .div_op_o(div_op_o), .div_result_i(div_result_i), .div_res_valid_i(div_res_valid_i),
        .div_res_ready_o(div_res_ready_o)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Divider answers this cycle, then both response channels accept
    task automatic complete(input logic [31:0] res);
        div_res_valid_i = 1'b1; div_result_i = res;
        step();
        div_res_valid_i = 1'b0; div_result_i = '0;
        rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
        step();
        rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid_i = 0; req1_valid_i = 0; rsp0_ready_i = 0; rsp1_ready_i = 0;
        req0_dividend_i = '0; req0_divisor_i = '0; req0_op_i = '0;
        req1_dividend_i = '0; req1_divisor_i = '0; req1_op_i = '0;
        div_res_valid_i = 0; div_result_i = '0;
        step(); step();
        n_checks++; if (div_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", div_start_o); end
        n_checks++; if ({rsp0_valid_o, rsp1_valid_o, div_res_ready_o} !== 3'b000) begin n_fail++; $display("FAIL reset_valids: got %b want 000", {rsp0_valid_o, rsp1_valid_o, div_res_ready_o}); end
        n_checks++; if ({rsp0_data_o, rsp1_data_o, div_dividend_o} !== 96'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {rsp0_data_o, rsp1_data_o, div_dividend_o}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        req0_valid_i = 1; req0_dividend_i = 32'd100; req0_divisor_i = 32'd7; req0_op_i = 3'b101;
        #1;
        n_checks++; if ({req0_ready_o, req1_ready_o} !== 2'b10) begin n_fail++; $display("FAIL single_grant: got %b want 10", {req0_ready_o, req1_ready_o}); end
        n_checks++; if (div_start_o !== 1'b0) begin n_fail++; $display("FAIL idle_start: got %b want 0", div_start_o); end
        step();
        req0_valid_i = 0; req0_dividend_i = 32'd999; req0_op_i = 3'b000;
        step(); step();
        n_checks++; if ({div_start_o, div_res_ready_o} !== 2'b11) begin n_fail++; $display("FAIL single_busy: got %b want 11", {div_start_o, div_res_ready_o}); end
        n_checks++; if ({div_dividend_o, div_divisor_o, div_op_o} !== {32'd100, 32'd7, 3'b101}) begin n_fail++; $display("FAIL single_operands: got %h want %h", {div_dividend_o, div_divisor_o, div_op_o}, {32'd100, 32'd7, 3'b101}); end
        div_res_valid_i = 1; div_result_i = 32'd14;
        step();
        div_res_valid_i = 0; div_result_i = '0;
        n_checks++; if ({rsp0_valid_o, rsp1_valid_o, rsp0_err_o, div_start_o} !== 4'b1000) begin n_fail++; $display("FAIL single_resp_flags: got %b want 1000", {rsp0_valid_o, rsp1_valid_o, rsp0_err_o, div_start_o}); end
        n_checks++; if (rsp0_data_o !== 32'd14) begin n_fail++; $display("FAIL single_data: got %0d want 14", rsp0_data_o); end
        rsp0_ready_i = 1;
        step();
        rsp0_ready_i = 0;
        n_checks++; if ({rsp0_valid_o, rsp1_valid_o, rsp0_data_o} !== 34'd0) begin n_fail++; $display("FAIL single_release: got %h want 0", {rsp0_valid_o, rsp1_valid_o, rsp0_data_o}); end
    endtask

    task automatic test_round_robin();
        rst = 1; step(); rst = 0;
        req0_valid_i = 1; req0_dividend_i = 32'hFFFF_FFEC; req0_divisor_i = 32'd3; req0_op_i = 3'b100;
        req1_valid_i = 1; req1_dividend_i = 32'd20;        req1_divisor_i = 32'd3; req1_op_i = 3'b111;
        #1;
        n_checks++; if ({req0_ready_o, req1_ready_o} !== 2'b10) begin n_fail++; $display("FAIL rr_first: got %b want 10", {req0_ready_o, req1_ready_o}); end
        step();
        req0_valid_i = 0;
        n_checks++; if ({div_dividend_o, div_op_o, req1_ready_o} !== {32'hFFFF_FFEC, 3'b100, 1'b0}) begin n_fail++; $display("FAIL rr_busy0: got %h want %h", {div_dividend_o, div_op_o, req1_ready_o}, {32'hFFFF_FFEC, 3'b100, 1'b0}); end
        div_res_valid_i = 1; div_result_i = 32'hFFFF_FFFA;
        step();
        div_res_valid_i = 0;
        n_checks++; if ({rsp0_valid_o, rsp1_valid_o, rsp0_data_o} !== {2'b10, 32'hFFFF_FFFA}) begin n_fail++; $display("FAIL rr_resp0: got %h want %h", {rsp0_valid_o, rsp1_valid_o, rsp0_data_o}, {2'b10, 32'hFFFF_FFFA}); end
        rsp0_ready_i = 1; step(); rsp0_ready_i = 0;
        n_checks++; if ({req0_ready_o, req1_ready_o} !== 2'b01) begin n_fail++; $display("FAIL rr_second: got %b want 01", {req0_ready_o, req1_ready_o}); end
        step();
        req1_valid_i = 0;
        n_checks++; if ({div_dividend_o, div_op_o} !== {32'd20, 3'b111}) begin n_fail++; $display("FAIL rr_busy1: got %h want %h", {div_dividend_o, div_op_o}, {32'd20, 3'b111}); end
        div_res_valid_i = 1; div_result_i = 32'd2;
        step();
        div_res_valid_i = 0;
        n_checks++; if ({rsp0_valid_o, rsp1_valid_o, rsp1_data_o, rsp1_err_o} !== {2'b01, 32'd2, 1'b0}) begin n_fail++; $display("FAIL rr_resp1: got %h want %h", {rsp0_valid_o, rsp1_valid_o, rsp1_data_o, rsp1_err_o}, {2'b01, 32'd2, 1'b0}); end
        rsp1_ready_i = 1; step(); rsp1_ready_i = 0;
        // Last grant was 1, so a simultaneous pair now goes to 0, and the next to 1
        req0_valid_i = 1; req1_valid_i = 1;
        #1;
        n_checks++; if ({req0_ready_o, req1_ready_o} !== 2'b10) begin n_fail++; $display("FAIL rr_pair2: got %b want 10", {req0_ready_o, req1_ready_o}); end
        step();
        complete(32'd5);
        #1;
        n_checks++; if ({req0_ready_o, req1_ready_o} !== 2'b01) begin n_fail++; $display("FAIL rr_pair3: got %b want 01", {req0_ready_o, req1_ready_o}); end
        step();
        req0_valid_i = 0; req1_valid_i = 0;
        complete(32'd6);
    endtask

    task automatic test_timeout();
        int n;
        req0_valid_i = 1; req0_dividend_i = 32'd1; req0_divisor_i = 32'd1; req0_op_i = 3'b101;
        step();
        req0_valid_i = 0;
        n = 0;
        while (div_start_o === 1'b1 && n < 300) begin n++; step(); end
        n_checks++; if (n !== 64) begin n_fail++; $display("FAIL timeout_busy_cycles: got %0d want 64", n); end
        n_checks++; if ({div_start_o, div_res_ready_o, rsp0_valid_o} !== 3'b000) begin n_fail++; $display("FAIL timeout_abort: got %b want 000", {div_start_o, div_res_ready_o, rsp0_valid_o}); end
        step();
        n_checks++; if ({rsp0_valid_o, rsp0_err_o, rsp0_data_o, rsp1_valid_o} !== {2'b11, 32'd0, 1'b0}) begin n_fail++; $display("FAIL timeout_resp: got %h want %h", {rsp0_valid_o, rsp0_err_o, rsp0_data_o, rsp1_valid_o}, {2'b11, 32'd0, 1'b0}); end
        rsp0_ready_i = 1; step(); rsp0_ready_i = 0;
    endtask

    task automatic test_hold();
        int bad;
        req0_valid_i = 1; req0_dividend_i = 32'd85; req0_divisor_i = 32'd1; req0_op_i = 3'b101;
        step();
        req0_valid_i = 0;
        div_res_valid_i = 1; div_result_i = 32'h55;
        step();
        div_res_valid_i = 0; div_result_i = '0;
        req1_valid_i = 1; req1_dividend_i = 32'd9; req1_divisor_i = 32'd4; req1_op_i = 3'b110;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if ({rsp0_valid_o, rsp0_data_o, rsp0_err_o, req1_ready_o, div_start_o} !== {1'b1, 32'h55, 3'b000}) bad++;
            step();
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
        n_checks++; if ({rsp0_valid_o, rsp0_data_o} !== {1'b1, 32'h55}) begin n_fail++; $display("FAIL hold_still_valid: got %h want %h", {rsp0_valid_o, rsp0_data_o}, {1'b1, 32'h55}); end
        rsp0_ready_i = 1; step(); rsp0_ready_i = 0;
        n_checks++; if ({req1_ready_o, rsp0_valid_o} !== 2'b10) begin n_fail++; $display("FAIL hold_grant_after: got %b want 10", {req1_ready_o, rsp0_valid_o}); end
        step();
        req1_valid_i = 0;
        n_checks++; if ({div_start_o, div_op_o, div_divisor_o} !== {1'b1, 3'b110, 32'd4}) begin n_fail++; $display("FAIL hold_req1_busy: got %h want %h", {div_start_o, div_op_o, div_divisor_o}, {1'b1, 3'b110, 32'd4}); end
        complete(32'd1);
    endtask

    task automatic test_reset_busy();
        int bad;
        req0_valid_i = 1; req0_dividend_i = 32'd50; req0_divisor_i = 32'd5; req0_op_i = 3'b101;
        step();
        req0_valid_i = 0;
        step();
        n_checks++; if (div_start_o !== 1'b1) begin n_fail++; $display("FAIL rstbusy_pre: got %b want 1", div_start_o); end
        rst = 1; step(); rst = 0;
        n_checks++; if ({div_start_o, div_res_ready_o} !== 2'b00) begin n_fail++; $display("FAIL rstbusy_start: got %b want 00", {div_start_o, div_res_ready_o}); end
        div_res_valid_i = 1; div_result_i = 32'd10;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            div_res_valid_i = 0;
            if ({rsp0_valid_o, rsp1_valid_o, div_start_o} !== 3'b000) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rstbusy_no_rsp: got %0d bad cycles want 0", bad); end
        req0_valid_i = 1; req1_valid_i = 1;
        #1;
        n_checks++; if ({req0_ready_o, req1_ready_o} !== 2'b10) begin n_fail++; $display("FAIL rstbusy_grant: got %b want 10", {req0_ready_o, req1_ready_o}); end
        step();
        req0_valid_i = 0; req1_valid_i = 0;
        complete(32'd3);
    endtask

    task automatic test_timeout_edge();
        req0_valid_i = 1; req0_dividend_i = 32'd7; req0_divisor_i = 32'd2; req0_op_i = 3'b111;
        step();
        req0_valid_i = 0;
        for (int i = 0; i < 63; i++) step();
        n_checks++; if (div_start_o !== 1'b1) begin n_fail++; $display("FAIL edge_last_busy: got %b want 1", div_start_o); end
        div_res_valid_i = 1; div_result_i = 32'h1234;
        step();
        div_res_valid_i = 0; div_result_i = '0;
        n_checks++; if ({rsp0_valid_o, rsp0_err_o, rsp0_data_o} !== {2'b10, 32'h1234}) begin n_fail++; $display("FAIL edge_accept: got %h want %h", {rsp0_valid_o, rsp0_err_o, rsp0_data_o}, {2'b10, 32'h1234}); end
        rsp0_ready_i = 1; step(); rsp0_ready_i = 0;
        n_checks++; if ({rsp0_valid_o, div_start_o} !== 2'b00) begin n_fail++; $display("FAIL edge_idle: got %b want 00", {rsp0_valid_o, div_start_o}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_hold();
        test_reset_busy();
        test_timeout_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_arb.md
DIV_ARB -- requirements
Module: div_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64; max cycles in BUSY before a divider operation is aborted (range 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have ports reqN_valid_i  input  1  requester N (N=0,1) request valid.
REQ-005 SHALL have ports reqN_ready_o  output  1  request accepted when high with reqN_valid_i.
REQ-006 SHALL have ports reqN_dividend_i / reqN_divisor_i  input  32  operands.
REQ-007 SHALL have ports reqN_op_i  input  3  DIV/DIVU/REM/REMU code, passed unmodified.
REQ-008 SHALL have ports rspN_valid_o  output  1 / rspN_ready_i  input  1  response handshake.
REQ-009 SHALL have ports rspN_data_o  output  32 / rspN_err_o  output  1  result, timeout flag.
REQ-010 SHALL have divider-side ports div_start_o  output  1, div_dividend_o / div_divisor_o  output  32, div_op_o  output  3.
REQ-011 SHALL have divider-side ports div_result_i  input  32, div_res_valid_i  input  1, div_res_ready_o  output  1.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, ABORT, RESP; exactly one active.
REQ-013 IDLE: reqN_ready_o SHALL be high only for the requester chosen by arbitration, combinationally, when that requester is valid.
REQ-014 Arbitration SHALL be round-robin: when both valid, grant the requester not granted last; when one valid, grant it.
REQ-015 On request handshake SHALL latch operands, op and owner ID, clear timeout counter, and go to BUSY next cycle.
REQ-016 BUSY: div_start_o SHALL be held 1 continuously; div_dividend_o/divisor_o/op_o SHALL show the latched values, stable throughout.
REQ-017 BUSY: div_res_ready_o SHALL be 1; on div_res_valid_i=1 SHALL latch div_result_i, set err=0, go to RESP.
REQ-018 BUSY: counter SHALL increment each cycle; if it reaches TIMEOUT without div_res_valid_i, go to ABORT (result valid in same cycle takes priority).
REQ-019 ABORT: lasts exactly 1 cycle, div_start_o=0, div_res_ready_o=0; latched result SHALL be 0, err=1; then RESP.
REQ-020 RESP: rspN_valid_o SHALL be 1 for the owner only, with rspN_data_o/rspN_err_o stable; div_start_o=0.
REQ-021 RESP: on owner rspN_ready_i=1 SHALL return to IDLE next cycle; new grant possible no earlier than that IDLE cycle.
REQ-022 Non-owner rspN_valid_o SHALL be 0 in all states; outputs outside RESP SHALL read 0.
REQ-023 Round-robin pointer SHALL update only at request handshake.
REQ-024 Divide-by-zero and signed overflow SHALL be handled by the divider; the arbiter passes its result unchanged.
REQ-025 Minimum request-to-response latency SHALL be divider latency + 2 cycles (grant, RESP entry).
REQ-026 reqN_valid_i deassertion before handshake SHALL be tolerated with no grant and no state change.
REQ-027 div_start_o SHALL be 0 in IDLE, so a new operation always begins from a deasserted start.

Reset
REQ-028 With rst=1 at a clock edge SHALL enter IDLE, round-robin pointer favouring requester 0, counter 0.
REQ-029 After reset all outputs SHALL be 0 except reqN_ready_o, which follows REQ-013.
REQ-030 Reset during BUSY SHALL drop div_start_o the next cycle, discarding the pending operation with no response issued.

Verification
REQ-031 Req0 DIVU 100/7, divider returns 14 -> rsp0_data_o=14, rsp0_err_o=0, rsp1_valid_o=0 throughout.
REQ-032 Both valid in same cycle after reset (req0 DIV -20/3, req1 REMU 20/3) -> req0 served first (-6), then req1 (2); pointer alternates on a second simultaneous pair.
REQ-033 Divider never asserts div_res_valid_i, TIMEOUT=64 -> after 64 BUSY cycles one ABORT cycle with div_start_o=0, then rsp_valid with data 0, err 1.
REQ-034 rsp0_ready_i held low 10 cycles in RESP -> data stable, no new grant despite req1_valid_i=1; grant to req1 in first IDLE cycle after release.
REQ-035 rst asserted mid-BUSY -> div_start_o=0 next cycle, no rsp_valid, next request granted to req0 if both valid.
REQ-036 Divider asserts div_res_valid_i on the cycle counter hits TIMEOUT -> result accepted, err=0, no ABORT.
